// File: rtl/t05_htree_pkg.sv
// Purpose: shared types, default widths and node-word helpers for the Huffman tree builder.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, default field widths, node field offsets,
//           pack_node()/null_node() for default-width node words.
package t05_htree_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_NODE,
    RD1,
    WR_NULL1,
    RD2,
    WR_NULL2,
    DONE,
    ERR
  } state_t;

  localparam int IDX_W_D     = 7;
  localparam int LEAF_W_D    = 9;
  localparam int SUM_W_D     = 46;
  localparam int MAX_NODES_D = 128;
  localparam int NODE_W_D    = IDX_W_D + 2*LEAF_W_D + SUM_W_D;

  // Node word layout, LSB first: sum | least2 | least1 | idx
  localparam int SUM_LSB_D = 0;
  localparam int L2_LSB_D  = SUM_LSB_D + SUM_W_D;
  localparam int L1_LSB_D  = L2_LSB_D + LEAF_W_D;
  localparam int IDX_LSB_D = L1_LSB_D + LEAF_W_D;

  function automatic logic [NODE_W_D-1:0] pack_node(
    input logic [IDX_W_D-1:0]  idx,
    input logic [LEAF_W_D-1:0] l1,
    input logic [LEAF_W_D-1:0] l2,
    input logic [SUM_W_D-1:0]  sum
  );
    return {idx, l1, l2, sum};
  endfunction

  // Keep a node's child fields, replace its index, zero its sum.
  function automatic logic [NODE_W_D-1:0] null_node(
    input logic [IDX_W_D-1:0]  idx,
    input logic [NODE_W_D-1:0] word
  );
    return {idx, word[L2_LSB_D +: 2*LEAF_W_D], {SUM_W_D{1'b0}}};
  endfunction

endpackage

// File: rtl/t05_htree_builder.sv
// Purpose: Huffman tree node builder; writes one internal node per triple, then nulls flagged children.
// Latency: 2 cycles per leaf-only triple (accept, write); +read latency +1 per internal child.
// Backpressure: in_ready only in IDLE with en; wr_valid/wr_data held until wr_ready; rd_req held until rd_valid.
// Ports: clk/rst_n (async active-low); en build enable (low aborts and clears);
//        in_* triple from min-finder; wr_* write and rd_* read to tree SRAM controller;
//        node_count nodes written, pair_done pulse, tree_done level, err sticky overflow.
module t05_htree_builder
  import t05_htree_pkg::*;
#(
  parameter int IDX_W     = IDX_W_D,
  parameter int LEAF_W    = LEAF_W_D,
  parameter int SUM_W     = SUM_W_D,
  parameter int MAX_NODES = MAX_NODES_D
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LEAF_W-1:0]                 in_least1,
  input  logic [LEAF_W-1:0]                 in_least2,
  input  logic [SUM_W-1:0]                  in_sum,
  output logic                              wr_valid,
  input  logic                              wr_ready,
  output logic [IDX_W-1:0]                  wr_addr,
  output logic [IDX_W+2*LEAF_W+SUM_W-1:0]   wr_data,
  output logic                              rd_req,
  output logic [IDX_W-1:0]                  rd_addr,
  input  logic                              rd_valid,
  input  logic [IDX_W+2*LEAF_W+SUM_W-1:0]   rd_data,
  output logic [IDX_W:0]                    node_count,
  output logic                              pair_done,
  output logic                              tree_done,
  output logic                              err
);

  localparam int NODE_W = IDX_W + 2*LEAF_W + SUM_W;
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_NODES);

  state_t           state;
  // Only the internal flag and the child index are needed after the node write.
  logic             l1_int, l2_int;
  logic [IDX_W-1:0] l1_idx, l2_idx;

  // Index and sum fields of a read-back child are replaced, not forwarded.
  logic unused_rd;
  assign unused_rd = ^{rd_data[NODE_W-1:SUM_W+2*LEAF_W], rd_data[SUM_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      node_count <= '0;
      pair_done  <= 1'b0;
      tree_done  <= 1'b0;
      err        <= 1'b0;
      l1_int     <= 1'b0;
      l2_int     <= 1'b0;
      l1_idx     <= '0;
      l2_idx     <= '0;
    end else if (!en) begin
      // Abort from any state; an outstanding read response is simply never consumed.
      state      <= IDLE;
      in_ready   <= 1'b0;
      wr_valid   <= 1'b0;
      rd_req     <= 1'b0;
      node_count <= '0;
      pair_done  <= 1'b0;
      tree_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      pair_done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            l1_int   <= in_least1[LEAF_W-1];
            l2_int   <= in_least2[LEAF_W-1];
            l1_idx   <= in_least1[IDX_W-1:0];
            l2_idx   <= in_least2[IDX_W-1:0];
            if (in_sum == '0) begin
              state     <= DONE;
              tree_done <= 1'b1;
            end else if (node_count == CNT_MAX) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state    <= WR_NODE;
              wr_valid <= 1'b1;
              wr_addr  <= node_count[IDX_W-1:0];
              wr_data  <= {node_count[IDX_W-1:0], in_least1, in_least2, in_sum};
            end
          end
        end

        WR_NODE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (node_count != CNT_MAX) node_count <= node_count + 1'b1;
            if (l1_int) begin
              state   <= RD1;
              rd_req  <= 1'b1;
              rd_addr <= l1_idx;
            end else if (l2_int) begin
              state   <= RD2;
              rd_req  <= 1'b1;
              rd_addr <= l2_idx;
            end else begin
              state     <= IDLE;
              pair_done <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
        end

        RD1, RD2: begin
          if (rd_valid) begin
            rd_req   <= 1'b0;
            state    <= (state == RD1) ? WR_NULL1 : WR_NULL2;
            wr_valid <= 1'b1;
            wr_addr  <= rd_addr;
            wr_data  <= {rd_addr, rd_data[SUM_W +: 2*LEAF_W], {SUM_W{1'b0}}};
          end
        end

        WR_NULL1: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (l2_int) begin
              state   <= RD2;
              rd_req  <= 1'b1;
              rd_addr <= l2_idx;
            end else begin
              state     <= IDLE;
              pair_done <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
        end

        WR_NULL2: begin
          if (wr_ready) begin
            wr_valid  <= 1'b0;
            state     <= IDLE;
            pair_done <= 1'b1;
            in_ready  <= 1'b1;
          end
        end

        // DONE and ERR are left only through en low or reset.
        DONE:    in_ready <= 1'b0;
        ERR:     in_ready <= 1'b0;
        default: state    <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_htree_builder.sv
// Purpose: directed bench for t05_htree_builder (MAX_NODES=4): vector table plus corner sequences.
// Latency: n/a.
// Backpressure: bench drives wr_ready stalls and read latencies explicitly.
module tb_t05_htree_builder;

  localparam int IDX_W  = 7;
  localparam int LEAF_W = 9;
  localparam int SUM_W  = 46;
  localparam int NODE_W = IDX_W + 2*LEAF_W + SUM_W;
  localparam int MAXN   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LEAF_W-1:0] in_least1 = '0;
  logic [LEAF_W-1:0] in_least2 = '0;
  logic [SUM_W-1:0]  in_sum = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [IDX_W-1:0]  wr_addr;
  logic [NODE_W-1:0] wr_data;
  logic              rd_req;
  logic [IDX_W-1:0]  rd_addr;
  logic              rd_valid = 1'b0;
  logic [NODE_W-1:0] rd_data = '0;
  logic [IDX_W:0]    node_count;
  logic              pair_done;
  logic              tree_done;
  logic              err;

  t05_htree_builder #(
    .IDX_W(IDX_W), .LEAF_W(LEAF_W), .SUM_W(SUM_W), .MAX_NODES(MAXN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_least1(in_least1), .in_least2(in_least2), .in_sum(in_sum),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .node_count(node_count), .pair_done(pair_done), .tree_done(tree_done), .err(err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscompares = 0;

  // Transaction logs captured on the handshake edges.
  logic [IDX_W-1:0]  wq_addr[$];
  logic [NODE_W-1:0] wq_data[$];
  logic [IDX_W-1:0]  rq_addr[$];
  int                rd_cycles = 0;

  always @(posedge clk) begin
    if (wr_valid && wr_ready) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (rd_req && rd_valid) rq_addr.push_back(rd_addr);
  end

  always @(negedge clk) if (rd_req) rd_cycles++;

  typedef struct {
    logic [LEAF_W-1:0] l1;
    logic [LEAF_W-1:0] l2;
    logic [SUM_W-1:0]  sum;
    logic [IDX_W-1:0]  eaddr;
    logic [NODE_W-1:0] edata;
    logic [IDX_W:0]    ecount;
  } vec_t;

  vec_t vt[3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    rq_addr.delete();
    rd_cycles = 0;
  endtask

  // Returns just after the accept edge.
  task automatic send(input logic [LEAF_W-1:0] l1, input logic [LEAF_W-1:0] l2,
                      input logic [SUM_W-1:0] sum);
    int n;
    in_least1 = l1;
    in_least2 = l2;
    in_sum    = sum;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for rd_req, answers after lat cycles of rd_req; returns just after the capture edge.
  task automatic serve_read(input int lat, input logic [NODE_W-1:0] d);
    int n;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    if (!rd_req) check("rd_req_timeout", {127'd0, rd_req}, 128'd1);
    repeat (lat - 1) tick();
    rd_data  = d;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic clear_build();
    en = 1'b0;
    tick();
    check("en_low_count", node_count, 0);
    en = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NODE_W-1:0] w, exp;
    logic stable;

    vt[0] = '{9'h041, 9'h042, 46'd5,  7'd0, {7'd0, 9'h041, 9'h042, 46'd5},  8'd1};
    vt[1] = '{9'h003, 9'h0A0, 46'd12, 7'd1, {7'd1, 9'h003, 9'h0A0, 46'd12}, 8'd2};
    vt[2] = '{9'h07F, 9'h000, 46'h3FFF_FFFF_FFFF, 7'd2,
              {7'd2, 9'h07F, 9'h000, 46'h3FFF_FFFF_FFFF}, 8'd3};

    // Reset state
    repeat (2) tick();
    check("rst_in_ready",   in_ready,   0);
    check("rst_wr_valid",   wr_valid,   0);
    check("rst_wr_addr",    wr_addr,    0);
    check("rst_wr_data",    wr_data,    0);
    check("rst_rd_req",     rd_req,     0);
    check("rst_rd_addr",    rd_addr,    0);
    check("rst_node_count", node_count, 0);
    check("rst_flags",      {pair_done, tree_done, err}, 0);
    rst_n    = 1'b1;
    en       = 1'b1;
    wr_ready = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1);

    // Leaf-only triples from the table, wr_ready always high
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      send(vt[i].l1, vt[i].l2, vt[i].sum);
      check($sformatf("v%0d_wr_valid", i), wr_valid, 1);
      check($sformatf("v%0d_wr_addr", i),  wr_addr,  vt[i].eaddr);
      check($sformatf("v%0d_wr_data", i),  wr_data,  vt[i].edata);
      check($sformatf("v%0d_busy", i),     {in_ready, pair_done}, 0);
      tick();
      check($sformatf("v%0d_pair_done", i), pair_done, 1);
      check($sformatf("v%0d_in_ready", i),  in_ready, 1);
      check($sformatf("v%0d_count", i),     node_count, vt[i].ecount);
      check($sformatf("v%0d_nwr", i),       wq_addr.size(), 1);
      check($sformatf("v%0d_logdata", i),   wq_data[0], vt[i].edata);
      tick();
      check($sformatf("v%0d_pulse", i),     pair_done, 0);
    end
    clear_build();

    // One internal child, 3-cycle read latency
    send(9'h041, 9'h042, 46'd5);
    tick();
    clear_logs();
    send(9'h100, 9'h043, 46'd9);
    check("t2_node_addr", wr_addr, 1);
    check("t2_node_data", wr_data, {7'd1, 9'h100, 9'h043, 46'd9});
    w = {7'h3A, 9'h055, 9'h066, 46'h123};
    serve_read(3, w);
    check("t2_null_valid", {wr_valid, rd_req}, 2'b10);
    check("t2_null_addr",  wr_addr, 0);
    check("t2_null_data",  wr_data, {7'd0, 9'h055, 9'h066, 46'd0});
    tick();
    check("t2_pair_done",  pair_done, 1);
    check("t2_count",      node_count, 2);
    check("t2_nwr",        wq_addr.size(), 2);
    check("t2_rd_cycles",  rd_cycles, 3);
    check("t2_rd_addr",    rq_addr[0], 0);

    // Two internal children, node write stalled 4 cycles
    clear_logs();
    wr_ready = 1'b0;
    send(9'h100, 9'h101, 46'd20);
    exp = {7'd2, 9'h100, 9'h101, 46'd20};
    check("t3_node_data", wr_data, exp);
    stable = 1'b1;
    repeat (4) begin
      tick();
      if (!(wr_valid && wr_addr == 7'd2 && wr_data == exp && !rd_req)) stable = 1'b0;
    end
    check("t3_stall_stable", {127'd0, stable}, 1);
    check("t3_stall_count", node_count, 2);
    wr_ready = 1'b1;
    serve_read(1, {7'h11, 9'h041, 9'h042, 46'd5});
    check("t3_null1_addr", wr_addr, 0);
    serve_read(2, {7'h22, 9'h003, 9'h0A0, 46'd12});
    check("t3_null2_data", wr_data, {7'd1, 9'h003, 9'h0A0, 46'd0});
    tick();
    check("t3_pair_done", pair_done, 1);
    check("t3_count",     node_count, 3);
    check("t3_nwr",       wq_addr.size(), 3);
    check("t3_order",     {wq_addr[0], wq_addr[1], wq_addr[2]}, {7'd2, 7'd0, 7'd1});
    check("t3_null1_log", wq_data[1], {7'd0, 9'h041, 9'h042, 46'd0});
    check("t3_rd_order",  {rq_addr[0], rq_addr[1]}, {7'd0, 7'd1});

    // Capacity: 4th node fills, 5th triple errors
    clear_logs();
    send(9'h001, 9'h002, 46'd4);
    tick();
    check("t4_fill_count", node_count, 4);
    send(9'h003, 9'h004, 46'd7);
    check("t4_err",       err, 1);
    check("t4_no_write",  {wr_valid, in_ready}, 0);
    repeat (2) tick();
    check("t4_err_held",  {err, in_ready, pair_done}, 3'b100);
    check("t4_sat_count", node_count, 4);
    check("t4_nwr",       wq_addr.size(), 1);
    en = 1'b0;
    tick();
    check("t4_err_clr",   {err, node_count}, 0);
    en = 1'b1;
    tick();

    // Tree complete
    clear_logs();
    send(9'h001, 9'h002, 46'd0);
    check("t5_tree_done", tree_done, 1);
    check("t5_no_access", {wr_valid, rd_req}, 0);
    repeat (3) tick();
    check("t5_held",      {tree_done, in_ready}, 2'b10);
    check("t5_nwr",       wq_addr.size() + rq_addr.size(), 0);
    en = 1'b0;
    tick();
    check("t5_clr",       tree_done, 0);
    en = 1'b1;
    tick();

    // Abort during RD1, late read response must be dropped
    clear_logs();
    send(9'h100, 9'h001, 46'd3);
    tick();
    check("t6_rd_req",    {rd_req, rd_addr}, {1'b1, 7'd0});
    en = 1'b0;
    tick();
    check("t6_abort",     {rd_req, wr_valid, node_count, pair_done}, 0);
    rd_data  = {7'h0, 9'h1FF, 9'h1FF, 46'd1};
    rd_valid = 1'b1;
    en       = 1'b1;
    tick();
    rd_valid = 1'b0;
    check("t6_ignored",   {wr_valid, rd_req}, 0);
    tick();
    check("t6_idle",      {wr_valid, in_ready}, 2'b01);
    check("t6_nwr",       wq_addr.size(), 1);
    check("t6_nrd",       rq_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
